// File: rtl/adc_buf_uart_reader_if.sv
// Buffer-read and UART-tx bundle for the ADC capture reader.
interface adc_buf_uart_reader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              rd_ce;
  logic              rd_oce;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, length, rd_data, tx_ready,
    output rd_ce, rd_oce, rd_addr, tx_data, tx_valid, busy, done
  );

  modport master (
    output start, base_addr, length, rd_data, tx_ready,
    input  rd_ce, rd_oce, rd_addr, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/adc_buf_uart_reader.sv
// Reads N bytes from the capture buffer and frames them for uart_tx:
// HDR0 HDR1 LEN_H LEN_L data... CKSUM.
module adc_buf_uart_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] HDR0 = 8'hA5,
  parameter logic [DATA_W-1:0] HDR1 = 8'h5A
) (
  input logic clk,
  input logic reset,
  adc_buf_uart_reader_if.slave bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_HDR0, ST_HDR1, ST_LENH, ST_LENL,
    ST_RDREQ, ST_RDWAIT, ST_DATA, ST_CKSUM, ST_DONE
  } state_t;

  localparam logic [ADDR_W:0] MAXLEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_rem;
  logic [DATA_W-1:0] r_cksum;
  logic [DATA_W-1:0] r_byte;

  logic [ADDR_W:0]   w_len;
  logic [15:0]       w_len16;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_ce;
  logic              w_busy;
  logic              w_done;
  logic              w_fire;

  assign w_len   = (bus.length > MAXLEN) ? MAXLEN : bus.length;
  assign w_len16 = 16'(r_len);
  assign w_fire  = w_valid & bus.tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_rem   <= '0;
      r_cksum <= '0;
      r_byte  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && bus.start) begin
        r_addr  <= bus.base_addr;
        r_len   <= w_len;
        r_rem   <= w_len;
        r_cksum <= '0;
      end
      if (r_state == ST_RDWAIT) begin
        r_byte <= bus.rd_data;
        r_addr <= r_addr + ADDR_W'(1);
        r_rem  <= r_rem - (ADDR_W+1)'(1);
      end
      if (r_state == ST_DATA && w_fire)
        r_cksum <= r_cksum + r_byte;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_data  = '0;
    w_ce    = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = ST_HDR0;
      end
      ST_HDR0: begin
        w_valid = 1'b1;
        w_data  = HDR0;
        if (bus.tx_ready) w_next = ST_HDR1;
      end
      ST_HDR1: begin
        w_valid = 1'b1;
        w_data  = HDR1;
        if (bus.tx_ready) w_next = ST_LENH;
      end
      ST_LENH: begin
        w_valid = 1'b1;
        w_data  = w_len16[15:8];
        if (bus.tx_ready) w_next = ST_LENL;
      end
      ST_LENL: begin
        w_valid = 1'b1;
        w_data  = w_len16[7:0];
        if (bus.tx_ready)
          w_next = (r_len != '0) ? ST_RDREQ : ST_CKSUM;
      end
      ST_RDREQ: begin
        w_ce   = 1'b1;
        w_next = ST_RDWAIT;
      end
      ST_RDWAIT: w_next = ST_DATA;
      ST_DATA: begin
        w_valid = 1'b1;
        w_data  = r_byte;
        if (bus.tx_ready)
          w_next = (r_rem != '0) ? ST_RDREQ : ST_CKSUM;
      end
      ST_CKSUM: begin
        w_valid = 1'b1;
        w_data  = r_cksum;
        if (bus.tx_ready) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  assign bus.rd_ce    = w_ce;
  assign bus.rd_oce   = 1'b1;
  assign bus.rd_addr  = r_addr;
  assign bus.tx_data  = w_data;
  assign bus.tx_valid = w_valid;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;

endmodule

// File: tb/tb_adc_buf_uart_reader.sv
// Randomized bench for adc_buf_uart_reader against a frame-level
// queue model of the buffer and the UART byte stream.
module tb_adc_buf_uart_reader;
  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adc_buf_uart_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  adc_buf_uart_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [7:0]    mem [4096];
  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [7:0]    got[$];
  logic [7:0]    lit[$];
  int vec = 0;
  int err = 0;
  int duty = 100;
  int done_cnt = 0;
  logic hold = 1'b0;
  logic [7:0] hold_data = '0;
  bit ok;

  // buffer in bypass read mode: data one cycle after ce
  always @(posedge clk)
    if (bus.rd_ce) bus.rd_data <= mem[bus.rd_addr];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.tx_ready = ($urandom_range(0, 99) < duty);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // per-cycle compare against the frame model
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      addr_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("tx_valid_held", bus.tx_valid, 1);
        if (bus.tx_valid) chk("tx_data_stable", bus.tx_data, hold_data);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        got.push_back(bus.tx_data);
        chk("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("tx_byte", bus.tx_data, exp_q.pop_front());
      end
      hold = bus.tx_valid && !bus.tx_ready;
      hold_data = bus.tx_data;
      if (bus.rd_ce) begin
        chk("rd_while_tx", bus.tx_valid, 0);
        chk("rd_oce", bus.rd_oce, 1);
        chk("rd_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) chk("rd_addr", bus.rd_addr, addr_q.pop_front());
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_busy", bus.busy, 0);
        chk("done_bytes_left", exp_q.size(), 0);
        chk("done_reads_left", addr_q.size(), 0);
      end
    end
  end

  task automatic prep(input int base, input int len);
    int n;
    int a;
    int sum;
    n = (len > 4096) ? 4096 : len;
    sum = 0;
    exp_q = {8'hA5, 8'h5A, 8'(n >> 8), 8'(n)};
    addr_q.delete();
    for (int i = 0; i < n; i++) begin
      a = (base + i) % 4096;
      addr_q.push_back(AW'(a));
      exp_q.push_back(mem[a]);
      sum += int'(mem[a]);
    end
    exp_q.push_back(8'(sum));
    got.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input int base, input int len);
    bus.base_addr = AW'(base);
    bus.length = (AW+1)'(len);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_frame(input int base, input int len, input int d,
                           input bit mid, output bit fin);
    int n;
    int bound;
    int w;
    n = (len > 4096) ? 4096 : len;
    duty = d;
    w = 0;
    while ((bus.busy || bus.done) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    prep(base, len);
    pulse_start(base, len);
    chk("busy_after_start", bus.busy, 1);
    bound = (n + 5) * 60 + 50;
    fin = 1'b0;
    for (int c = 0; c < bound; c++) begin
      if (mid && c == 8) begin
        bus.base_addr = AW'($urandom_range(0, 4095));
        bus.length = (AW+1)'($urandom_range(1, 50));
        bus.start = 1'b1;
      end
      if (mid && c == 9) bus.start = 1'b0;
      if (bus.done) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("frame_done", fin, 1);
    if (!fin) begin
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
    end
    @(negedge clk);
    chk("done_pulses", done_cnt, 1);
  endtask

  task automatic check_lit(input string nm);
    chk({nm, "_size"}, got.size(), lit.size());
    for (int i = 0; i < lit.size(); i++)
      if (i < got.size()) chk(nm, got[i], lit[i]);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_rd_ce", bus.rd_ce, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
    run_frame(0, 4, 100, 1'b0, ok);
    lit = {8'hA5, 8'h5A, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    check_lit("frame_basic");

    mem[4094] = 8'h10;
    mem[4095] = 8'h20;
    mem[0] = 8'h30;
    mem[1] = 8'h40;
    run_frame(4094, 4, 100, 1'b0, ok);
    lit = {8'hA5, 8'h5A, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
    check_lit("frame_wrap");

    run_frame(123, 0, 100, 1'b0, ok);
    lit = {8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00};
    check_lit("frame_len0");

    run_frame(7, 5000, 100, 1'b0, ok);
    chk("clamp_size", got.size(), 4101);
    if (got.size() > 3) begin
      chk("clamp_len_h", got[2], 8'h10);
      chk("clamp_len_l", got[3], 8'h00);
    end

    for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
    run_frame(0, 4, 30, 1'b0, ok);
    lit = {8'hA5, 8'h5A, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    check_lit("frame_slow");

    run_frame(50, 6, 100, 1'b1, ok);
    chk("mid_start_size", got.size(), 11);

    duty = 100;
    prep(200, 20);
    pulse_start(200, 20);
    for (int c = 0; c < 200; c++) begin
      if (got.size() >= 6 && bus.tx_valid) break;
      @(negedge clk);
    end
    chk("reached_data", got.size() >= 6 && bus.tx_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_tx_valid", bus.tx_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd_ce", bus.rd_ce, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame(200, 20, 70, 1'b0, ok);
    chk("after_abort_size", got.size(), 25);

    for (int i = 0; i < 256; i++) mem[300 + i] = 8'hFF;
    run_frame(300, 256, 100, 1'b0, ok);
    chk("ff_size", got.size(), 261);
    if (got.size() == 261) chk("ff_cksum", got[260], 8'h00);
    run_frame(0, 4, 100, 1'b0, ok);
    lit = {8'hA5, 8'h5A, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    check_lit("back_to_back");

    for (int k = 0; k < 6; k++) begin
      int b;
      int l;
      b = $urandom_range(0, 4095);
      l = $urandom_range(0, 300);
      run_frame(b, l, $urandom_range(30, 100), 1'b0, ok);
      chk("rand_size", got.size(), l + 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
